// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/baud constants, transmitter FSM state type, tag helper.
// The TAG state exists only when UART_TX_TAG_EN is defined.
package uart_pkg;

    localparam int CLK_FREQ_HZ         = 50_000_000;
    localparam int CLKS_PER_BIT_230400 = 217;
    localparam int CLKS_PER_BIT_115200 = 434;
    localparam logic [7:0] TAG_BASE    = 8'hA0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
`ifdef UART_TX_TAG_EN
        ,
        ST_TAG   = 3'd4
`endif
    } tx_state_t;

    function automatic logic [7:0] tag_byte(input logic [2:0] gid);
        return TAG_BASE | {5'b00000, gid};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping at NUM_REQ-1.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   grant,
    output logic               any_req
);

    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0] hit;
    logic [PTR_W-1:0]   cand [NUM_REQ];

    // One candidate per search offset; the wrap is explicit so non-power-of-two counts work.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_off
        logic [PTR_W:0] sum;
        assign sum      = {1'b0, rr_ptr} + (PTR_W + 1)'(gi);
        assign cand[gi] = (sum >= NUM_REQ_W) ? PTR_W'(sum - NUM_REQ_W) : PTR_W'(sum);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) grant = cand[k];
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 RS232 transmitter among NUM_REQ byte requesters.
// Define UART_TX_TAG_EN to send a tag frame (0xA0 | GRANT_ID) ahead of every data frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_230400,
    localparam int GID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   CLK_50M,
    input  logic                   RST_N,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    input  logic [8*NUM_REQ-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]     REQ_READY,
    output logic                   RS232_DCE_TXD,
    output logic                   BUSY,
    output logic [GID_W-1:0]       GRANT_ID
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [3:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_data_reg, shift_data_next;
    logic [GID_W-1:0] gid_reg, gid_next;
    logic [GID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic             txd_reg, txd_next;
    logic             busy_reg, busy_next;

    logic [GID_W-1:0] grant;
    logic             any_req;
    logic             bit_done;
    logic             accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (GID_W)
    ) u_rr_arbiter (
        .req     (REQ_VALID),
        .rr_ptr  (rr_ptr_reg),
        .grant   (grant),
        .any_req (any_req)
    );

    assign bit_done = (baud_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            state_reg      <= ST_IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_data_reg <= '0;
            gid_reg        <= '0;
            rr_ptr_reg     <= '0;
            txd_reg        <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_cnt_reg   <= baud_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_data_reg <= shift_data_next;
            gid_reg        <= gid_next;
            rr_ptr_reg     <= rr_ptr_next;
            txd_reg        <= txd_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        baud_cnt_next   = baud_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_data_next = shift_data_reg;
        gid_next        = gid_reg;
        rr_ptr_next     = rr_ptr_reg;
        if (state_reg != ST_IDLE) begin
            baud_cnt_next = bit_done ? '0 : baud_cnt_reg + 1'b1;
        end
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    shift_data_next = REQ_DATA[{grant, 3'b000} +: 8];
                    gid_next        = grant;
                    rr_ptr_next     = (grant == GID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    bit_idx_next    = '0;
`ifdef UART_TX_TAG_EN
                    state_next      = ST_TAG;
`else
                    state_next      = ST_START;
`endif
                end
            end
`ifdef UART_TX_TAG_EN
            // Whole tag frame (start, 8 bits, stop) lives here; bit_idx walks 0..9.
            ST_TAG: begin
                if (bit_done) begin
                    if (bit_idx_reg == 4'd9) begin
                        bit_idx_next = '0;
                        state_next   = ST_START;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
`endif
            ST_START: begin
                if (bit_done) begin
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_data_next = {1'b0, shift_data_reg[7:1]};
                    if (bit_idx_reg == 4'd7) begin
                        bit_idx_next = '0;
                        state_next   = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // TXD and BUSY are registered from the next state so they line up with state_reg.
    always_comb begin
`ifdef UART_TX_TAG_EN
        logic [9:0] tag_bits;
        tag_bits = {1'b1, tag_byte(3'(gid_next)), 1'b0};
`endif
        txd_next  = 1'b1;
        busy_next = (state_next != ST_IDLE);
        case (state_next)
            ST_START: txd_next = 1'b0;
            ST_DATA:  txd_next = shift_data_next[0];
`ifdef UART_TX_TAG_EN
            ST_TAG:   txd_next = tag_bits[bit_idx_next];
`endif
            default:  txd_next = 1'b1;
        endcase
    end

    assign accept = (state_reg == ST_IDLE) && any_req && RST_N;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign REQ_READY[gi] = accept && (grant == GID_W'(gi));
    end

    assign RS232_DCE_TXD = txd_reg;
    assign BUSY          = busy_reg;
    assign GRANT_ID      = gid_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive the handshake, a serial
// decoder pops expected frames; honours UART_TX_TAG_EN for tag+data frame pairs.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N        = 3;
    localparam int CPB      = 4;
    localparam int CPB_SLOW = 217;
`ifdef UART_TX_TAG_EN
    localparam int FRAMES   = 2;
    localparam int LOW_BITS = 16;
`else
    localparam int FRAMES   = 1;
    localparam int LOW_BITS = 9;
`endif
    localparam int BUSY_LEN = FRAMES * 10 * CPB;
    localparam int PRE      = (FRAMES - 1) * 10 * CPB;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             txd, busy;
    logic [1:0]       grant_id;

    logic [1:0]       s_valid;
    logic [15:0]      s_data;
    logic [1:0]       s_ready;
    logic             s_txd, s_busy;
    logic [0:0]       s_gid;

    uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB)) dut (
        .CLK_50M(clk), .RST_N(rst_n), .REQ_VALID(req_valid), .REQ_DATA(req_data),
        .REQ_READY(req_ready), .RS232_DCE_TXD(txd), .BUSY(busy), .GRANT_ID(grant_id)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .CLKS_PER_BIT(CPB_SLOW)) dut_slow (
        .CLK_50M(clk), .RST_N(rst_n), .REQ_VALID(s_valid), .REQ_DATA(s_data),
        .REQ_READY(s_ready), .RS232_DCE_TXD(s_txd), .BUSY(s_busy), .GRANT_ID(s_gid)
    );

    typedef struct {
        logic [7:0] data;
        int         gid;
        int         gap;
        bit         first;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] src_q [N][$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_ready_cyc = 0;
    int frame_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int gid, input bit chained);
        int gap;
        gap = chained ? 10 * CPB + 1 : 0;
`ifdef UART_TX_TAG_EN
        exp_q.push_back('{8'hA0 | 8'(gid), gid, gap, 1'b1});
        exp_q.push_back('{d, gid, 10 * CPB, 1'b0});
`else
        exp_q.push_back('{d, gid, gap, 1'b1});
`endif
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pending() != 0 || busy !== 1'b0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        check({name, "_timeout"}, (n >= limit) ? 1 : 0, 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // Requesters: hold VALID/DATA until READY is seen, then present the next queued byte.
    initial begin : requester_driver
        logic [N-1:0] taken;
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            taken = req_ready & req_valid;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (taken[i]) src_q[i].delete(0);
                if (src_q[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[8*i +: 8]   = src_q[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin : handshake_monitor
        forever begin
            @(negedge clk);
            if (|req_ready) begin
                last_ready_cyc = cyc;
                check("ready_onehot", $onehot(req_ready) ? 1 : 0, 1);
                check("ready_while_busy", busy, 0);
                check("ready_without_valid", |(req_ready & ~req_valid) ? 1 : 0, 0);
            end
        end
    end

    initial begin : busy_monitor
        int  run;
        bit  hit_reset;
        run = 0;
        hit_reset = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                run++;
                if (rst_n !== 1'b1) hit_reset = 1'b1;
            end else begin
                if (run > 0 && !hit_reset) check("busy_len", run, BUSY_LEN);
                run = 0;
                hit_reset = 1'b0;
            end
        end
    end

    // Serial decoder: samples every cycle of all 10 bits so bit length is checked exactly.
    initial begin : serial_monitor
        logic [9:0] bits;
        bit   stable, aborted;
        int   t0, gid_seen, last_start;
        exp_t e;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) begin
                t0 = cyc;
                gid_seen = grant_id;
                stable = 1'b1;
                aborted = 1'b0;
                bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                        if (c == 0) bits[b] = txd;
                        else if (txd !== bits[b]) stable = 1'b0;
                    end
                end
                if (aborted) begin
                    $display("frame aborted by reset, started at cycle %0d", t0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(bits[8:1]), -1);
                end else begin
                    e = exp_q.pop_front();
                    frame_no++;
                    $display("frame %0d: byte 0x%02h grant %0d start cycle %0d", frame_no, bits[8:1], gid_seen, t0);
                    check("frame_data", 32'(bits[8:1]), 32'(e.data));
                    check("frame_start_stop_stable", 32'({bits[9], bits[0], stable}), 32'b101);
                    check("frame_grant_id", gid_seen, e.gid);
                    if (e.gap != 0) check("start_gap", t0 - last_start, e.gap);
                    if (e.first) check("ready_to_start", t0 - last_ready_cyc, 1);
                end
                last_start = t0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish within 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n, busy_cnt, low_cnt;
        rst_n   = 1'b0;
        s_valid = '0;
        s_data  = '0;

        // Reset state, with a request already waiting
        src_q[0].push_back(8'h55);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        expect_frame(8'h55, 0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_done("single", 2000);

        // Two simultaneous requesters
        apply_reset();
        expect_frame(8'h11, 0, 1'b0);
        expect_frame(8'h22, 1, 1'b1);
        src_q[0].push_back(8'h11);
        src_q[1].push_back(8'h22);
        wait_done("pair", 2000);

        // Three continuously valid requesters, seven frames
        apply_reset();
        for (int i = 1; i <= 7; i++) expect_frame(8'(i), (i - 1) % 3, i > 1);
        for (int i = 1; i <= 7; i++) src_q[(i - 1) % 3].push_back(8'(i));
        wait_done("rotation", 4000);

        // Reset during DATA bit 3 of a frame from req1
        apply_reset();
`ifdef UART_TX_TAG_EN
        exp_q.push_back('{8'hA1, 1, 0, 1'b1});
`endif
        src_q[1].push_back(8'h96);
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("abort_grant_timeout", (n >= 100) ? 1 : 0, 0);
        repeat (18 + PRE) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_txd", txd, 1);
        check("abort_busy", busy, 0);
        check("abort_grant_id", grant_id, 0);
        repeat (60) @(posedge clk);
        #1;
        check("abort_queue", exp_q.size(), 0);
        expect_frame(8'h3A, 0, 1'b0);
        expect_frame(8'hC3, 2, 1'b1);
        src_q[2].push_back(8'hC3);
        src_q[0].push_back(8'h3A);
        wait_done("after_abort", 2000);

        // req1 alone (tag 0xA1 first when tagging is built in)
        expect_frame(8'h3C, 1, 1'b0);
        src_q[1].push_back(8'h3C);
        wait_done("req1_single", 2000);

        // Real baud: 0x00 at 217 clocks per bit
        @(posedge clk); #1;
        s_valid = 2'b01;
        n = 0;
        while (s_ready[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("slow_grant_timeout", (n >= 100) ? 1 : 0, 0);
        @(posedge clk); #1 s_valid = 2'b00;
        busy_cnt = 0;
        low_cnt  = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (s_busy === 1'b1) busy_cnt++;
            if (s_busy === 1'b1 && s_txd === 1'b0) low_cnt++;
            n++;
        end while ((busy_cnt == 0 || s_busy === 1'b1) && n < 6000);
        $display("slow frame: busy %0d cycles (%0d ns), txd low %0d cycles", busy_cnt, busy_cnt * 20, low_cnt);
        check("slow_busy_cycles", busy_cnt, FRAMES * 10 * CPB_SLOW);
        check("slow_low_cycles", low_cnt, LOW_BITS * CPB_SLOW);
        check("slow_grant_id", s_gid, 0);

        repeat (5) @(posedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
